ls_region_router: RTL and testbench
===================================

Name: ls_region_router

Overview:
- Parametrised successor to the fixed scratch/ACP/bus memory-source selection used by the load-store path.
- Decodes each load/store address against NUM_REGIONS programmable regions and forwards the request to exactly one sub-unit.
- Tracks outstanding loads in a tag FIFO so load data returns to the writeback path in issue order across regions.
- Generates an error response for loads to unmapped addresses.

Parameters:
- NUM_REGIONS, 4: number of sub-unit regions (1-8).
- REGION_ADDR_L, {32'h00020000, 32'h00030000, 32'h00020000, 32'h0}: packed NUM_REGIONS*32 base addresses; index 0 is the LSBs.
- REGION_BIT_CHECK, {16, 16, 15, 0}: packed NUM_REGIONS*6; number of upper address bits compared. 0 disables the region.
- MAX_OUTSTANDING, 4: tag FIFO depth, power of 2, 2-16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  32  byte address
- req_we  in  1  1=store, 0=load
- req_wdata  in  32  store data
- req_be  in  4  byte enables
- sub_valid  out  NUM_REGIONS  one-hot forward valid
- sub_ready  in  NUM_REGIONS  per-region ready
- sub_addr/sub_wdata/sub_be/sub_we  out  32/32/4/1  shared, equal to req_* combinationally
- sub_rvalid  in  NUM_REGIONS  single-cycle load data pulse, no backpressure
- sub_rdata  in  NUM_REGIONS*32  load data
- rsp_valid  out  1  single-cycle load response
- rsp_data  out  32  load data, 0 on error
- rsp_err  out  1  unmapped-load response
- bad_store  out  1  registered pulse: unmapped store dropped
- proto_err  out  1  sticky: sub_rvalid from a non-head region or with FIFO empty
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  loads in flight
- idle  out  1  outstanding==0

Behaviour:
- Decode (combinational): region i hits if BIT_CHECK[i]!=0 and req_addr[31:32-BIT_CHECK[i]] == ADDR_L[i][31:32-BIT_CHECK[i]]. The lowest hitting index wins, so overlapping regions resolve to scratch before bus. No hit means unmapped.
- sub_valid[t] = req_valid & mapped & (req_we | !fifo_full), where t is the winning region. All other bits are 0.
- req_ready:
  - mapped load: sub_ready[t] & !fifo_full
  - mapped store: sub_ready[t]
  - unmapped load: !fifo_full
  - unmapped store: 1
  - No full-with-pop bypass.
- Load accept pushes the tag {err, region} into the FIFO. Stores are not tracked.
- Unmapped store: no sub_valid is asserted; bad_store pulses the next cycle.
- Response (combinational from head):
  - head non-error: rsp_valid = sub_rvalid[head.region], rsp_data = that region's rdata, rsp_err = 0.
  - head error: rsp_valid = 1, rsp_data = 0, rsp_err = 1.
  - rsp_valid pops the head.
  - Latency: error response in the cycle after accept at the earliest; data response in the same cycle as sub_rvalid.
- Simultaneous push and pop: count unchanged, both applied. Pointers wrap modulo MAX_OUTSTANDING.
- Any sub_rvalid[j] with FIFO empty, or with j != head.region (or with head.err set), sets proto_err. That data is dropped and the FIFO is unchanged.
- Reset state:
  - FIFO pointers 0, outstanding 0, idle 1.
  - rsp_valid 0, bad_store 0, proto_err 0.
  - sub_valid 0 while FIFO state is reset.
- Reset mid-operation discards all tags. Sub-units share rst, so no stale responses follow.
- Per-region response ordering is the sub-unit's responsibility (in-order within a region).

Test Plan:
- Load 0x00020010, sub0 ready, rvalid+rdata=0xDEADBEEF 2 cycles later -> sub_valid=0001, rsp_valid 1 cycle with 0xDEADBEEF, rsp_err=0, idle returns to 1.
- Load 0x00021000 with default params -> region 0 wins over region 2. Load 0x00030040 -> region 1. Load 0x00010000 -> rsp_err=1, rsp_data=0 the next cycle, no sub_valid.
- Load to region 1 then region 0; region 0 rvalid fires first -> proto_err=1, no rsp. Region 1 rvalid then gives rsp with region 1 data, head advances.
- 4 loads with no responses -> outstanding=4, req_ready=0 for a 5th load while a store to a ready region is still accepted. One response then frees a slot next cycle.
- Store to 0x00050000 -> req_ready=1, sub_valid=0, bad_store pulses once.
- rst asserted with 3 loads outstanding -> next cycle outstanding=0, idle=1, proto_err=0; a new load completes normally.

Source files
------------

// File: rtl/ls_region_router.sv
// Load-store region router: decodes each request against programmable address
// regions, forwards it to exactly one sub-unit, and returns load data to the
// writeback path in issue order using a small tag FIFO. Loads to unmapped
// addresses get an error response. Unmapped stores are dropped and flagged.
module ls_region_router #(
  parameter int NUM_REGIONS = 4,
  // Index 0 occupies the least significant bits of each packed vector.
  // Region 0 (scratch) and region 2 (bus window) overlap; region 0 wins.
  parameter logic [NUM_REGIONS*32-1:0] REGION_ADDR_L    = {32'h0, 32'h00020000, 32'h00030000, 32'h00020000},
  parameter logic [NUM_REGIONS*6-1:0]  REGION_BIT_CHECK = {6'd0, 6'd15, 6'd16, 6'd16},
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [31:0]                          req_addr,
  input  logic                                 req_we,
  input  logic [31:0]                          req_wdata,
  input  logic [3:0]                           req_be,
  output logic [NUM_REGIONS-1:0]               sub_valid,
  input  logic [NUM_REGIONS-1:0]               sub_ready,
  output logic [31:0]                          sub_addr,
  output logic [31:0]                          sub_wdata,
  output logic [3:0]                           sub_be,
  output logic                                 sub_we,
  input  logic [NUM_REGIONS-1:0]               sub_rvalid,
  input  logic [NUM_REGIONS*32-1:0]            sub_rdata,
  output logic                                 rsp_valid,
  output logic [31:0]                          rsp_data,
  output logic                                 rsp_err,
  output logic                                 bad_store,
  output logic                                 proto_err,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 idle
);

  localparam int IDXW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int PTRW = $clog2(MAX_OUTSTANDING);
  localparam int CNTW = PTRW + 1;
  localparam int TAGW = IDXW + 1;

  // Mask selecting the upper 'bits' address bits of a region compare.
  function automatic logic [31:0] region_mask(input int bits);
    logic [31:0] m;
    if (bits <= 0) begin
      m = '0;
    end else if (bits >= 32) begin
      m = '1;
    end else begin
      m = ~((32'h1 << (32 - bits)) - 32'h1);
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] win_onehot;
  logic [IDXW-1:0]        win_idx;
  logic                   mapped;
  logic                   win_ready;

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_decode
    localparam int          BITS = int'(REGION_BIT_CHECK[gi*6 +: 6]);
    localparam logic [31:0] MASK = region_mask(BITS);
    localparam logic [31:0] BASE = REGION_ADDR_L[gi*32 +: 32];
    if (BITS == 0) begin : g_off
      assign hit[gi] = 1'b0;
    end else begin : g_on
      assign hit[gi] = ((req_addr ^ BASE) & MASK) == 32'h0;
    end
  end

  assign mapped     = |hit;
  // Isolate the lowest set hit bit so the lowest-numbered region wins.
  assign win_onehot = hit & (~hit + NUM_REGIONS'(1));
  assign win_ready  = |(win_onehot & sub_ready);

  // Encode the winning region index (lowest index wins).
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx = IDXW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Tag FIFO state
  // ---------------------------------------------------------------------
  logic [TAGW-1:0] fifo_mem_q [MAX_OUTSTANDING];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            bad_store_q, bad_store_d;
  logic            proto_err_q, proto_err_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            push;
  logic            pop;

  assign fifo_full  = (count_q == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // ---------------------------------------------------------------------
  // Request handshake and forwarding
  // ---------------------------------------------------------------------
  logic ready_raw;

  // Loads need a free tag slot; unmapped stores are always swallowed.
  always_comb begin
    ready_raw = 1'b0;
    if (mapped) begin
      ready_raw = req_we ? win_ready : (win_ready & ~fifo_full);
    end else begin
      ready_raw = req_we ? 1'b1 : ~fifo_full;
    end
  end

  // Nothing is accepted or forwarded while the tag state is held in reset.
  assign req_ready = ready_raw & ~rst;
  assign sub_valid = (req_valid & mapped & (req_we | ~fifo_full) & ~rst) ? win_onehot : '0;
  assign accept    = req_valid & req_ready;
  assign push      = accept & ~req_we;

  assign sub_addr  = req_addr;
  assign sub_wdata = req_wdata;
  assign sub_be    = req_be;
  assign sub_we    = req_we;

  // ---------------------------------------------------------------------
  // Response path from the FIFO head
  // ---------------------------------------------------------------------
  logic [TAGW-1:0]        head_tag;
  logic                   head_err;
  logic [IDXW-1:0]        head_region;
  logic                   head_rvalid;
  logic [31:0]            head_rdata;
  logic [NUM_REGIONS-1:0] head_onehot;
  logic [NUM_REGIONS-1:0] expect_mask;
  logic                   stray_rvalid;

  assign head_tag    = fifo_mem_q[rd_ptr_q];
  assign head_err    = head_tag[TAGW-1];
  assign head_region = head_tag[IDXW-1:0];

  // Select the return channel of the region that owns the head tag.
  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    head_onehot = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (head_region == IDXW'(i)) begin
        head_rvalid    = sub_rvalid[i];
        head_rdata     = sub_rdata[i*32 +: 32];
        head_onehot[i] = 1'b1;
      end
    end
  end

  // Only the head region may return data; anything else is a protocol fault.
  assign expect_mask  = (fifo_empty | head_err) ? '0 : head_onehot;
  assign stray_rvalid = |(sub_rvalid & ~expect_mask);

  // Error tags retire immediately; data tags retire on the owner's rvalid.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    if (!fifo_empty && !rst) begin
      if (head_err) begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end else begin
        rsp_valid = head_rvalid;
        rsp_data  = head_rdata;
      end
    end
  end

  assign pop = rsp_valid;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTRW'(push);
    rd_ptr_d    = rd_ptr_q + PTRW'(pop);
    count_d     = count_q + CNTW'(push) - CNTW'(pop);
    bad_store_d = accept & req_we & ~mapped;
    proto_err_d = proto_err_q | stray_rvalid;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bad_store_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bad_store_q <= bad_store_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {~mapped, win_idx};
    end
  end

  assign outstanding = count_q;
  assign idle        = fifo_empty;
  assign bad_store   = bad_store_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_ls_region_router.sv
// Self-checking bench for ls_region_router with default parameters.
module tb_ls_region_router;

  localparam int NR = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [31:0] cyc;
  } obs_t;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            req_we;
  logic [31:0]     req_wdata;
  logic [3:0]      req_be;
  logic [NR-1:0]   sub_valid;
  logic [NR-1:0]   sub_ready;
  logic [31:0]     sub_addr;
  logic [31:0]     sub_wdata;
  logic [3:0]      sub_be;
  logic            sub_we;
  logic [NR-1:0]   sub_rvalid;
  logic [NR*32-1:0] sub_rdata;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            bad_store;
  logic            proto_err;
  logic [2:0]      outstanding;
  logic            idle;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] cyc = 0;

  ls_region_router dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_addr(sub_addr),
    .sub_wdata(sub_wdata), .sub_be(sub_be), .sub_we(sub_we),
    .sub_rvalid(sub_rvalid), .sub_rdata(sub_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bad_store(bad_store), .proto_err(proto_err),
    .outstanding(outstanding), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every response the DUT produces, mid-cycle.
  always @(negedge clk) begin
    if (!rst && rsp_valid) obs_q.push_back({rsp_err, rsp_data, cyc});
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Drive a request until accepted (bounded); returns at 1ns after the accept edge.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       output logic acc, output logic [3:0] sv, output logic [31:0] acyc);
    req_addr = addr; req_we = we; req_wdata = wdata; req_be = 4'hF; req_valid = 1'b1;
    acc = 1'b0; sv = '0; acyc = '0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1; sv = sub_valid; acyc = cyc;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // One-cycle return pulse from region r.
  task automatic pulse(input int r, input logic [31:0] d, output logic [31:0] pcyc);
    sub_rvalid = 4'(1 << r);
    sub_rdata = '0;
    sub_rdata[r*32 +: 32] = d;
    pcyc = cyc;
    @(posedge clk); #1;
    sub_rvalid = '0;
  endtask

  // Wait (bounded) until the monitor has captured a response.
  task automatic wait_obs(output logic got);
    got = (obs_q.size() > 0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = (obs_q.size() > 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h00020010; req_we = 1'b0;
    sub_ready = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (sub_valid !== 4'b0000) begin $display("FAIL reset_sub_valid: got %b expected 0000", sub_valid); mismatched++; end
    compared++; if (outstanding !== 3'd0) begin $display("FAIL reset_outstanding: got %0d expected 0", outstanding); mismatched++; end
    compared++; if (idle !== 1'b1) begin $display("FAIL reset_idle: got %b expected 1", idle); mismatched++; end
    compared++; if ({rsp_valid, bad_store, proto_err} !== 3'b000) begin $display("FAIL reset_flags: got %b expected 000", {rsp_valid, bad_store, proto_err}); mismatched++; end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    compared++; if (outstanding !== 3'd0) begin $display("FAIL post_reset_outstanding: got %0d expected 0", outstanding); mismatched++; end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    logic acc, got; logic [3:0] sv; logic [31:0] acyc, pcyc; obs_t o; exp_t e;
    sub_ready = 4'b0001;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    issue(32'h00020010, 1'b0, 32'h0, acc, sv, acyc);
    compared++; if (acc !== 1'b1) begin $display("FAIL basic_accept: got %b expected 1", acc); mismatched++; end
    compared++; if (sv !== 4'b0001) begin $display("FAIL basic_sub_valid: got %b expected 0001", sv); mismatched++; end
    compared++; if (outstanding !== 3'd1 || idle !== 1'b0) begin $display("FAIL basic_inflight: got %0d/%b expected 1/0", outstanding, idle); mismatched++; end
    @(posedge clk); #1;
    pulse(0, 32'hDEADBEEF, pcyc);
    compared++; if (idle !== 1'b1) begin $display("FAIL basic_idle_after: got %b expected 1", idle); mismatched++; end
    wait_obs(got);
    compared++; if (got !== 1'b1) begin $display("FAIL basic_rsp_seen: got %b expected 1", got); mismatched++; end
    if (got) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if ({o.err, o.data} !== e) begin $display("FAIL basic_rsp: got %b/%h expected %b/%h", o.err, o.data, e.err, e.data); mismatched++; end
      compared++; if (o.cyc !== pcyc) begin $display("FAIL basic_rsp_cycle: got %0d expected %0d", o.cyc, pcyc); mismatched++; end
    end
    repeat (3) begin @(posedge clk); #1; end
    compared++; if (obs_q.size() !== 0) begin $display("FAIL basic_single_rsp: got %0d extra expected 0", obs_q.size()); mismatched++; end
  endtask

  task automatic test_decode();
    logic acc, got; logic [3:0] sv; logic [31:0] acyc, pcyc; obs_t o; exp_t e;
    sub_ready = 4'hF;
    exp_q.push_back({1'b0, 32'h11111111});
    issue(32'h00021000, 1'b0, 32'h0, acc, sv, acyc);
    compared++; if (sv !== 4'b0001) begin $display("FAIL decode_overlap: got %b expected 0001", sv); mismatched++; end
    pulse(0, 32'h11111111, pcyc);
    wait_obs(got);
    compared++; if (got !== 1'b1) begin $display("FAIL decode_r0_seen: got %b expected 1", got); mismatched++; end
    if (got) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if ({o.err, o.data} !== e) begin $display("FAIL decode_r0_rsp: got %b/%h expected %b/%h", o.err, o.data, e.err, e.data); mismatched++; end
    end
    exp_q.push_back({1'b0, 32'h22222222});
    issue(32'h00030040, 1'b0, 32'h0, acc, sv, acyc);
    compared++; if (sv !== 4'b0010) begin $display("FAIL decode_r1: got %b expected 0010", sv); mismatched++; end
    pulse(1, 32'h22222222, pcyc);
    wait_obs(got);
    compared++; if (got !== 1'b1) begin $display("FAIL decode_r1_seen: got %b expected 1", got); mismatched++; end
    if (got) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if ({o.err, o.data} !== e) begin $display("FAIL decode_r1_rsp: got %b/%h expected %b/%h", o.err, o.data, e.err, e.data); mismatched++; end
    end
    exp_q.push_back({1'b1, 32'h0});
    issue(32'h00010000, 1'b0, 32'h0, acc, sv, acyc);
    compared++; if (acc !== 1'b1 || sv !== 4'b0000) begin $display("FAIL decode_unmapped_fwd: got %b/%b expected 1/0000", acc, sv); mismatched++; end
    wait_obs(got);
    compared++; if (got !== 1'b1) begin $display("FAIL decode_err_seen: got %b expected 1", got); mismatched++; end
    if (got) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if ({o.err, o.data} !== e) begin $display("FAIL decode_err_rsp: got %b/%h expected %b/%h", o.err, o.data, e.err, e.data); mismatched++; end
      compared++; if (o.cyc !== acyc + 1) begin $display("FAIL decode_err_latency: got %0d expected %0d", o.cyc, acyc + 1); mismatched++; end
    end
    @(posedge clk); #1;
    compared++; if (idle !== 1'b1) begin $display("FAIL decode_idle: got %b expected 1", idle); mismatched++; end
  endtask

  task automatic test_proto_err();
    logic acc, got; logic [3:0] sv; logic [31:0] acyc, pcyc; obs_t o; exp_t e;
    sub_ready = 4'hF;
    compared++; if (proto_err !== 1'b0) begin $display("FAIL proto_pre: got %b expected 0", proto_err); mismatched++; end
    exp_q.push_back({1'b0, 32'hA1A1A1A1});
    issue(32'h00030000, 1'b0, 32'h0, acc, sv, acyc);
    exp_q.push_back({1'b0, 32'hB0B0B0B0});
    issue(32'h00020000, 1'b0, 32'h0, acc, sv, acyc);
    pulse(0, 32'hBADBAD00, pcyc);
    compared++; if (proto_err !== 1'b1) begin $display("FAIL proto_set: got %b expected 1", proto_err); mismatched++; end
    compared++; if (obs_q.size() !== 0) begin $display("FAIL proto_no_rsp: got %0d expected 0", obs_q.size()); mismatched++; end
    compared++; if (outstanding !== 3'd2) begin $display("FAIL proto_fifo_kept: got %0d expected 2", outstanding); mismatched++; end
    pulse(1, 32'hA1A1A1A1, pcyc);
    pulse(0, 32'hB0B0B0B0, pcyc);
    for (int k = 0; k < 2; k++) begin
      wait_obs(got);
      compared++; if (got !== 1'b1) begin $display("FAIL proto_rsp%0d_seen: got %b expected 1", k, got); mismatched++; end
      if (got) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        compared++; if ({o.err, o.data} !== e) begin $display("FAIL proto_rsp%0d: got %b/%h expected %b/%h", k, o.err, o.data, e.err, e.data); mismatched++; end
      end
    end
    compared++; if (outstanding !== 3'd0 || proto_err !== 1'b1) begin $display("FAIL proto_end: got %0d/%b expected 0/1", outstanding, proto_err); mismatched++; end
  endtask

  task automatic test_full();
    logic acc, got; logic [3:0] sv; logic [31:0] acyc, pcyc; obs_t o; exp_t e;
    sub_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 32'hC0 + 32'(k)});
      issue(32'h00020000 + 32'(k * 4), 1'b0, 32'h0, acc, sv, acyc);
      compared++; if (acc !== 1'b1) begin $display("FAIL full_fill%0d: got %b expected 1", k, acc); mismatched++; end
    end
    compared++; if (outstanding !== 3'd4) begin $display("FAIL full_count: got %0d expected 4", outstanding); mismatched++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00020100;
    @(negedge clk);
    compared++; if (req_ready !== 1'b0 || sub_valid !== 4'b0000) begin $display("FAIL full_load_blocked: got %b/%b expected 0/0000", req_ready, sub_valid); mismatched++; end
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h00030008; req_wdata = 32'h55AA55AA;
    @(negedge clk);
    compared++; if (req_ready !== 1'b1 || sub_valid !== 4'b0010) begin $display("FAIL full_store_ok: got %b/%b expected 1/0010", req_ready, sub_valid); mismatched++; end
    compared++; if (sub_we !== 1'b1 || sub_wdata !== 32'h55AA55AA || sub_addr !== 32'h00030008) begin $display("FAIL full_store_fwd: got %b/%h/%h expected 1/55aa55aa/00030008", sub_we, sub_wdata, sub_addr); mismatched++; end
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h00020100;
    sub_rvalid = 4'b0001; sub_rdata = '0; sub_rdata[31:0] = 32'hC0;
    @(negedge clk);
    compared++; if (req_ready !== 1'b0) begin $display("FAIL full_no_bypass: got %b expected 0", req_ready); mismatched++; end
    @(posedge clk); #1;
    sub_rvalid = '0;
    @(negedge clk);
    compared++; if (outstanding !== 3'd3 || req_ready !== 1'b1) begin $display("FAIL full_slot_freed: got %0d/%b expected 3/1", outstanding, req_ready); mismatched++; end
    exp_q.push_back({1'b0, 32'hC4});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) pulse(0, 32'hC0 + 32'(k), pcyc);
    for (int k = 0; k < 5; k++) begin
      wait_obs(got);
      compared++; if (got !== 1'b1) begin $display("FAIL full_rsp%0d_seen: got %b expected 1", k, got); mismatched++; end
      if (got) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        compared++; if ({o.err, o.data} !== e) begin $display("FAIL full_rsp%0d: got %b/%h expected %b/%h", k, o.err, o.data, e.err, e.data); mismatched++; end
      end
    end
  endtask

  task automatic test_bad_store();
    logic acc; logic [3:0] sv; logic [31:0] acyc;
    sub_ready = 4'hF;
    compared++; if (bad_store !== 1'b0) begin $display("FAIL bad_store_pre: got %b expected 0", bad_store); mismatched++; end
    issue(32'h00050000, 1'b1, 32'h12345678, acc, sv, acyc);
    compared++; if (acc !== 1'b1 || sv !== 4'b0000) begin $display("FAIL bad_store_accept: got %b/%b expected 1/0000", acc, sv); mismatched++; end
    compared++; if (bad_store !== 1'b1) begin $display("FAIL bad_store_pulse: got %b expected 1", bad_store); mismatched++; end
    @(posedge clk); #1;
    compared++; if (bad_store !== 1'b0 || outstanding !== 3'd0) begin $display("FAIL bad_store_once: got %b/%0d expected 0/0", bad_store, outstanding); mismatched++; end
  endtask

  task automatic test_reset_mid();
    logic acc, got; logic [3:0] sv; logic [31:0] acyc, pcyc; obs_t o; exp_t e;
    sub_ready = 4'hF;
    for (int k = 0; k < 3; k++) issue(32'h00020000, 1'b0, 32'h0, acc, sv, acyc);
    compared++; if (outstanding !== 3'd3 || proto_err !== 1'b1) begin $display("FAIL rstmid_pre: got %0d/%b expected 3/1", outstanding, proto_err); mismatched++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++; if (outstanding !== 3'd0 || idle !== 1'b1 || proto_err !== 1'b0) begin $display("FAIL rstmid_state: got %0d/%b/%b expected 0/1/0", outstanding, idle, proto_err); mismatched++; end
    obs_q.delete();
    exp_q.push_back({1'b0, 32'h0D0D0D0D});
    issue(32'h00020000, 1'b0, 32'h0, acc, sv, acyc);
    compared++; if (sv !== 4'b0001) begin $display("FAIL rstmid_fwd: got %b expected 0001", sv); mismatched++; end
    pulse(0, 32'h0D0D0D0D, pcyc);
    wait_obs(got);
    compared++; if (got !== 1'b1) begin $display("FAIL rstmid_seen: got %b expected 1", got); mismatched++; end
    if (got) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if ({o.err, o.data} !== e) begin $display("FAIL rstmid_rsp: got %b/%h expected %b/%h", o.err, o.data, e.err, e.data); mismatched++; end
    end
    compared++; if (idle !== 1'b1 || proto_err !== 1'b0) begin $display("FAIL rstmid_end: got %b/%b expected 1/0", idle, proto_err); mismatched++; end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
    req_be = 4'hF; sub_ready = '0; sub_rvalid = '0; sub_rdata = '0;
    test_reset();
    test_basic_load();
    test_decode();
    test_proto_err();
    test_full();
    test_bad_store();
    test_reset_mid();
    compared++; if (exp_q.size() !== 0 || obs_q.size() !== 0) begin $display("FAIL leftover: got %0d/%0d expected 0/0", exp_q.size(), obs_q.size()); mismatched++; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
